// File: rtl/sha256_msg_loader.sv
// Streams message words into memory, then appends SHA-256 padding
// (0x80 marker, zero fill, 64-bit bit-length) and pulses hash_start.
module sha256_msg_loader #(
  parameter int MAX_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load_req,
  input  logic [15:0] base_addr,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  input  logic        in_last,
  output logic        in_ready,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [31:0] mem_write_data,
  output logic        hash_start,
  output logic [15:0] msg_words,
  output logic [7:0]  num_blocks,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE, LOAD, PAD80, ZERO, LEN_HI, LEN_LO, START
  } state_t;

  localparam logic [15:0] LAST_IDX = 16'(MAX_WORDS - 1);

  state_t      state, state_nxt;
  logic [15:0] base_q;
  logic [15:0] off_q;
  logic [15:0] zero_end_q;
  logic        accept, final_beat;
  logic [15:0] n_next, blocks_next;
  logic        we_d, start_d;
  logic [15:0] addr_d;
  logic [31:0] data_d;

  assign in_ready    = (state == LOAD);
  assign busy        = (state != IDLE);
  assign accept      = in_valid && in_ready;
  assign final_beat  = accept && (in_last || off_q == LAST_IDX);
  assign n_next      = off_q + 16'd1;
  assign blocks_next = ((n_next + 16'd2) >> 4) + 16'd1;

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // off_q is the single running word offset shared by data and padding writes,
  // so ZERO ends when it reaches the last zero-fill slot (16B-3).
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (load_req) state_nxt = LOAD;
      LOAD:    if (final_beat) state_nxt = PAD80;
      PAD80:   state_nxt = (off_q == zero_end_q) ? LEN_HI : ZERO;
      ZERO:    if (off_q == zero_end_q) state_nxt = LEN_HI;
      LEN_HI:  state_nxt = LEN_LO;
      LEN_LO:  state_nxt = START;
      START:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    we_d    = 1'b0;
    start_d = 1'b0;
    addr_d  = mem_addr;
    data_d  = mem_write_data;
    case (state)
      LOAD: if (accept) begin
        we_d   = 1'b1;
        addr_d = base_q + off_q;
        data_d = in_data;
      end
      PAD80: begin
        we_d   = 1'b1;
        addr_d = base_q + off_q;
        data_d = 32'h8000_0000;
      end
      ZERO, LEN_HI: begin
        we_d   = 1'b1;
        addr_d = base_q + off_q;
        data_d = 32'h0000_0000;
      end
      LEN_LO: begin
        we_d   = 1'b1;
        addr_d = base_q + off_q;
        data_d = {11'd0, msg_words, 5'd0};
      end
      START:   start_d = 1'b1;
      default: ;
    endcase
  end

  // Outputs are registered from the decode above, so every write and the
  // start pulse appear one cycle after the state that produced them.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mem_we         <= 1'b0;
      mem_addr       <= 16'd0;
      mem_write_data <= 32'd0;
      hash_start     <= 1'b0;
      msg_words      <= 16'd0;
      num_blocks     <= 8'd0;
      base_q         <= 16'd0;
      off_q          <= 16'd0;
      zero_end_q     <= 16'd0;
    end else begin
      mem_we         <= we_d;
      mem_addr       <= addr_d;
      mem_write_data <= data_d;
      hash_start     <= start_d;
      if (state == IDLE && load_req) begin
        base_q <= base_addr;
        off_q  <= 16'd0;
      end else if (we_d) begin
        off_q <= off_q + 16'd1;
      end
      if (final_beat) begin
        msg_words  <= n_next;
        num_blocks <= blocks_next[7:0];
        zero_end_q <= (blocks_next << 4) - 16'd3;
      end
    end
  end

endmodule

// File: tb/tb_sha256_msg_loader.sv
// Directed bench: records every memory write and compares the image, counts
// and timing against hand-computed SHA-256 padding layouts.
module tb_sha256_msg_loader;

  localparam logic [31:0] SEED = 32'h0123_4675;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        load_req;
  logic [15:0] base_addr;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_last;
  logic        in_ready;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_write_data;
  logic        hash_start;
  logic [15:0] msg_words;
  logic [7:0]  num_blocks;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] img [int];
  int          wcyc [int];
  int          writes, dups, starts;
  int          cyc = 0, lastCyc = -100, startCyc = -200;
  logic [15:0] lastAddr;

  sha256_msg_loader #(.MAX_WORDS(1024)) dut (
    .clk(clk), .reset_n(reset_n), .load_req(load_req), .base_addr(base_addr),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_write_data(mem_write_data), .hash_start(hash_start),
    .msg_words(msg_words), .num_blocks(num_blocks), .busy(busy)
  );

  always #5 clk = ~clk;

  // Write monitor: samples the registered memory port on the falling edge.
  always @(negedge clk) begin
    cyc++;
    if (mem_we) begin
      if (img.exists(int'(mem_addr))) dups++;
      img[int'(mem_addr)]  = mem_write_data;
      wcyc[int'(mem_addr)] = cyc;
      writes++;
      lastAddr = mem_addr;
      lastCyc  = cyc;
    end
    if (hash_start) begin
      starts++;
      startCyc = cyc;
    end
  end

  function automatic logic [31:0] rotl1(input logic [31:0] w);
    return {w[30:0], w[31]};
  endfunction

  function automatic logic [31:0] expWord(input int i, input int n, input int b);
    logic [31:0] w;
    w = SEED;
    if (i < n) begin
      for (int j = 0; j < i; j++) w = rotl1(w);
      return w;
    end
    if (i == n) return 32'h8000_0000;
    if (i == 16*b - 1) return 32'(n * 32);
    return 32'h0;
  endfunction

  function automatic logic [31:0] memAt(input int a);
    if (img.exists(a)) return img[a];
    return 32'hXXXX_XXXX;
  endfunction

  function automatic int cycAt(input int a);
    if (wcyc.exists(a)) return wcyc[a];
    return -1000;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] base, input int n, input bit gaps, input int abortAt);
    int  k, iter;
    bit  skip, acc;
    logic [31:0] w;
    img.delete(); wcyc.delete();
    writes = 0; dups = 0; starts = 0;
    @(negedge clk);
    load_req = 1'b1; base_addr = base;
    @(negedge clk);
    load_req = 1'b0;
    checkOutput("in_ready_in_load", 32'(in_ready), 32'd1);
    k = 0; iter = 0; skip = 1'b0; w = SEED;
    while (k < n && iter < 4*n + 20) begin
      if (abortAt > 0 && k == abortAt) break;
      in_valid  = !(gaps && skip);
      in_data   = in_valid ? w : 32'hDEAD_BEEF;
      in_last   = (k == n - 1);
      load_req  = (iter == 2);
      base_addr = (iter == 2) ? 16'h5555 : base;
      acc = in_valid && in_ready;
      @(negedge clk);
      load_req = 1'b0;
      if (acc) begin
        k++;
        w = rotl1(w);
      end
      skip = !skip;
      iter++;
    end
    in_valid = 1'b0; in_last = 1'b0; in_data = 32'h0;
    if (abortAt == 0) checkOutput("beats_accepted", 32'(k), 32'(n));
  endtask

  task automatic waitDone();
    int t;
    t = 0;
    while (starts == 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic checkLoad(input string tag, input logic [15:0] base, input int n, input int b);
    int bad;
    int aN, aLast;
    bad = 0;
    for (int i = 0; i < 16*b; i++) begin
      if (memAt(int'(16'(base + 16'(i)))) !== expWord(i, n, b)) bad++;
    end
    aN    = int'(16'(base + 16'(n)));
    aLast = int'(16'(base + 16'(16*b - 1)));
    checkOutput({tag, "_image"},      32'(bad), 32'd0);
    checkOutput({tag, "_writes"},     32'(writes), 32'(16*b));
    checkOutput({tag, "_dups"},       32'(dups), 32'd0);
    checkOutput({tag, "_starts"},     32'(starts), 32'd1);
    checkOutput({tag, "_start_lat"},  32'(startCyc - lastCyc), 32'd1);
    checkOutput({tag, "_last_addr"},  32'(lastAddr), 32'(aLast));
    checkOutput({tag, "_pad_contig"}, 32'(cycAt(aLast) - cycAt(aN)), 32'(16*b - 1 - n));
    checkOutput({tag, "_msg_words"},  32'(msg_words), 32'(n));
    checkOutput({tag, "_num_blocks"}, 32'(num_blocks), 32'(b));
    checkOutput({tag, "_busy"},       32'(busy), 32'd0);
  endtask

  initial begin
    reset_n = 1'b0; load_req = 1'b0; base_addr = 16'h0;
    in_valid = 1'b0; in_data = 32'h0; in_last = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_busy",       32'(busy), 32'd0);
    checkOutput("rst_in_ready",   32'(in_ready), 32'd0);
    checkOutput("rst_mem_we",     32'(mem_we), 32'd0);
    checkOutput("rst_hash_start", 32'(hash_start), 32'd0);
    checkOutput("rst_mem_addr",   32'(mem_addr), 32'd0);
    checkOutput("rst_mem_data",   mem_write_data, 32'd0);
    checkOutput("rst_counts",     {8'd0, num_blocks, msg_words}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // N=30 from base 0: three blocks, length 960 bits.
    applyStimulus(16'h0000, 30, 1'b0, 0);
    waitDone();
    checkLoad("n30", 16'h0000, 30, 3);
    checkOutput("n30_w1",  memAt(1),  32'h0246_8CEA);
    checkOutput("n30_w29", memAt(29), 32'hA024_68CE);
    checkOutput("n30_w30", memAt(30), 32'h8000_0000);
    checkOutput("n30_w46", memAt(46), 32'h0000_0000);
    checkOutput("n30_w47", memAt(47), 32'h0000_03C0);

    // N=13: marker and length fit in one block with no zero fill.
    applyStimulus(16'h0100, 13, 1'b0, 0);
    waitDone();
    checkLoad("n13", 16'h0100, 13, 1);
    checkOutput("n13_w10d", memAt(16'h010D), 32'h8000_0000);
    checkOutput("n13_w10e", memAt(16'h010E), 32'h0000_0000);
    checkOutput("n13_w10f", memAt(16'h010F), 32'h0000_01A0);

    // N=5 with in_valid low every other cycle.
    applyStimulus(16'h0200, 5, 1'b1, 0);
    waitDone();
    checkLoad("gap5", 16'h0200, 5, 1);
    checkOutput("gap5_w205", memAt(16'h0205), 32'h8000_0000);
    checkOutput("gap5_w20f", memAt(16'h020F), 32'h0000_00A0);

    // Address wrap past 0xFFFF.
    applyStimulus(16'hFFFA, 3, 1'b0, 0);
    waitDone();
    checkLoad("wrap3", 16'hFFFA, 3, 1);
    checkOutput("wrap3_wfffd", memAt(16'hFFFD), 32'h8000_0000);
    checkOutput("wrap3_w0009", memAt(16'h0009), 32'h0000_0060);

    // Reset after 10 of 30 words aborts the load.
    applyStimulus(16'h0000, 30, 1'b0, 10);
    reset_n = 1'b0;
    @(negedge clk);
    checkOutput("abort_busy",     32'(busy), 32'd0);
    checkOutput("abort_mem_we",   32'(mem_we), 32'd0);
    checkOutput("abort_in_ready", 32'(in_ready), 32'd0);
    checkOutput("abort_counts",   {8'd0, num_blocks, msg_words}, 32'd0);
    writes = 0; starts = 0;
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    checkOutput("abort_no_writes", 32'(writes), 32'd0);
    checkOutput("abort_no_start",  32'(starts), 32'd0);

    // N=14 after the abort: two blocks, zero fill 15..29.
    applyStimulus(16'h0000, 14, 1'b0, 0);
    waitDone();
    checkLoad("n14", 16'h0000, 14, 2);
    checkOutput("n14_w14", memAt(14), 32'h8000_0000);
    checkOutput("n14_w29", memAt(29), 32'h0000_0000);
    checkOutput("n14_w31", memAt(31), 32'h0000_01C0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
